// File: rtl/emissor_registro_if.sv
// Bus bundle between the keypad/sequencer side and emissor_registro.
// hab/fim: a word on out_word is offered while hab=1, is taken when the latch raises fim, and the next word waits until fim has cleared.
interface emissor_registro_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wr_en;
  logic [3:0]    wr_oper;
  logic [3:0]    wr_dado;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [7:0]    out_word;
  logic          hab;
  logic          fim;
  logic          busy;
  logic          enviado;
  logic          erro;
  logic          clr_erro;
  logic [1:0]    fsm_state;

  modport master (
    output wr_en, wr_oper, wr_dado, fim, clr_erro,
    input  full, empty, count, out_word, hab, busy, enviado, erro, fsm_state
  );

  modport slave (
    input  wr_en, wr_oper, wr_dado, fim, clr_erro,
    output full, empty, count, out_word, hab, busy, enviado, erro, fsm_state
  );
endinterface

// File: rtl/emissor_registro.sv
// Transmit side of the Hab/Fim operand-latch handshake: FIFO of {oper,dado} words fed to the latch.
// Optional drive timeout is enabled by defining EMISSOR_TIMEOUT_EN.
module emissor_registro #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  emissor_registro_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop;
  logic [7:0]    out_word_q, out_word_d;
  logic          hab_q, hab_d;
  logic          enviado_q, enviado_d;
`ifdef EMISSOR_TIMEOUT_EN
  logic          erro_q, erro_d;
  logic [7:0]    timer, timer_d;
`endif

  assign bus.full      = (cnt == CW'(DEPTH));
  assign bus.empty     = (cnt == '0);
  assign bus.count     = cnt;
  assign bus.out_word  = out_word_q;
  assign bus.hab       = hab_q;
  assign bus.enviado   = enviado_q;
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;
  assign push          = bus.wr_en && !bus.full;

`ifdef EMISSOR_TIMEOUT_EN
  assign bus.erro = erro_q;
`else
  logic unused_clr_erro;
  assign unused_clr_erro = bus.clr_erro;
  assign bus.erro        = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    out_word_d = out_word_q;
    hab_d      = hab_q;
    enviado_d  = 1'b0;
    pop        = 1'b0;
`ifdef EMISSOR_TIMEOUT_EN
    timer_d    = timer;
    erro_d     = erro_q;
    if (bus.clr_erro) erro_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        // A fim left high from the previous word holds us here until it clears.
        if (!bus.empty && !bus.fim) begin
          state_d    = DRIVE;
          out_word_d = mem[rd_ptr];
          pop        = 1'b1;
          hab_d      = 1'b1;
`ifdef EMISSOR_TIMEOUT_EN
          timer_d    = 8'd0;
`endif
        end
      end
      DRIVE: begin
        if (bus.fim) begin
          state_d   = RELEASE;
          hab_d     = 1'b0;
          enviado_d = 1'b1;
        end
`ifdef EMISSOR_TIMEOUT_EN
        else if (timer == 8'(TIMEOUT - 1)) begin
          // Word is abandoned; the timeout overrides a same-cycle clr_erro.
          state_d = RELEASE;
          hab_d   = 1'b0;
          erro_d  = 1'b1;
        end else begin
          timer_d = timer + 8'd1;
        end
`endif
      end
      RELEASE: begin
        if (!bus.fim) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_word_q <= 8'h00;
      hab_q      <= 1'b0;
      enviado_q  <= 1'b0;
`ifdef EMISSOR_TIMEOUT_EN
      erro_q     <= 1'b0;
      timer      <= 8'd0;
`endif
    end else begin
      state      <= state_d;
      out_word_q <= out_word_d;
      hab_q      <= hab_d;
      enviado_q  <= enviado_d;
`ifdef EMISSOR_TIMEOUT_EN
      erro_q     <= erro_d;
      timer      <= timer_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.wr_oper, bus.wr_dado};
  end
endmodule

// File: tb/tb_emissor_registro.sv
// Bench for emissor_registro: protocol-level model checked every cycle plus directed scenarios.
module tb_emissor_registro;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int P_FREE  = 0;
  localparam int P_SEND  = 1;
  localparam int P_WAIT  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  emissor_registro_if #(.DEPTH(DEPTH)) bus ();
  emissor_registro #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Latch stand-in: answers fim two cycles after hab, drops it once hab falls.
  logic latch_auto = 1'b0;
  logic fim_man    = 1'b0;
  logic fim_auto   = 1'b0;
  int   lat_cnt    = 0;
  assign bus.fim = latch_auto ? fim_auto : fim_man;

  always @(negedge clk) begin
    if (rst) begin
      lat_cnt  = 0;
      fim_auto = 1'b0;
    end else if (bus.hab) begin
      lat_cnt++;
      if (lat_cnt >= 2) fim_auto = 1'b1;
    end else begin
      lat_cnt  = 0;
      fim_auto = 1'b0;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at the last rising edge.
  logic       s_rst = 1'b1, s_wr = 1'b0, s_fim = 1'b0, s_clr = 1'b0;
  logic [3:0] s_oper = '0, s_dado = '0;
  always @(posedge clk) begin
    s_rst  <= rst;
    s_wr   <= bus.wr_en;
    s_oper <= bus.wr_oper;
    s_dado <= bus.wr_dado;
    s_fim  <= bus.fim;
    s_clr  <= bus.clr_erro;
  end

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         m_phase = P_FREE;
  int         m_timer = 0;
  logic       m_hab = 1'b0, m_env = 1'b0, m_erro = 1'b0;
  logic [7:0] m_word = 8'h00;

  always @(negedge clk) begin : model_blk
    bit was_full;
    if (rst || s_rst) begin
      exp_q.delete();
      m_phase = P_FREE;
      m_timer = 0;
      m_hab   = 1'b0;
      m_env   = 1'b0;
      m_erro  = 1'b0;
      m_word  = 8'h00;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      m_env    = 1'b0;
`ifdef EMISSOR_TIMEOUT_EN
      if (s_clr) m_erro = 1'b0;
`endif
      if (m_phase == P_FREE) begin
        if (exp_q.size() > 0 && !s_fim) begin
          m_word  = exp_q.pop_front();
          m_hab   = 1'b1;
          m_timer = 0;
          m_phase = P_SEND;
        end
      end else if (m_phase == P_SEND) begin
        if (s_fim) begin
          m_hab   = 1'b0;
          m_env   = 1'b1;
          m_phase = P_WAIT;
        end
`ifdef EMISSOR_TIMEOUT_EN
        else if (m_timer == TIMEOUT - 1) begin
          m_hab   = 1'b0;
          m_erro  = 1'b1;
          m_phase = P_WAIT;
        end else begin
          m_timer++;
        end
`endif
      end else begin
        if (!s_fim) m_phase = P_FREE;
      end
      if (s_wr && !was_full) exp_q.push_back({s_oper, s_dado});
    end
    chk("hab",      bus.hab,      m_hab);
    chk("out_word", bus.out_word, m_word);
    chk("enviado",  bus.enviado,  m_env);
    chk("count",    bus.count,    exp_q.size());
    chk("full",     bus.full,     exp_q.size() == DEPTH);
    chk("empty",    bus.empty,    exp_q.size() == 0);
    chk("busy",     bus.busy,     m_phase != P_FREE);
    chk("erro",     bus.erro,     m_erro);
    if (bus.enviado === 1'b1) got_q.push_back(bus.out_word);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [3:0] o, input logic [3:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_oper = o;
    bus.wr_dado = d;
  endtask

  task automatic stop_wr();
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_hab(input logic v, input int lim, input string nm);
    int i;
    i = 0;
    while (bus.hab !== v && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(nm, bus.hab, v);
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int i;
    i = 0;
    while (!(bus.empty === 1'b1 && bus.busy === 1'b0) && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk(nm, {bus.empty, bus.busy}, 2'b10);
  endtask

  task automatic hab_len(output int len);
    len = 0;
    while (bus.hab === 1'b1 && len < 60) begin
      @(negedge clk);
      len++;
    end
  endtask

  logic [7:0] w3[5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

  initial begin
    int len;
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_oper  = 4'h0;
    bus.wr_dado  = 4'h0;
    bus.clr_erro = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("reset_hab",   bus.hab,      1'b0);
    chk("reset_word",  bus.out_word, 8'h00);
    chk("reset_count", bus.count,    3'd0);
    chk("reset_empty", bus.empty,    1'b1);

    // Single word through the latch stand-in.
    latch_auto = 1'b1;
    got_q.delete();
    push_word(4'h3, 4'h5);
    stop_wr();
    @(negedge clk);
    chk("t2_latency", bus.hab, 1'b1);
    chk("t2_word", bus.out_word, 8'h35);
    hab_len(len);
    chk("t2_hab_len", len, 2);
    wait_idle(20, "t2_idle");
    chk("t2_sent", got_q.size(), 1);
    if (got_q.size() == 1) chk("t2_sent_word", got_q[0], 8'h35);

    // Burst of five while a stale fim holds the FIFO still.
    latch_auto = 1'b0;
    fim_man    = 1'b1;
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("t3_full_after_4", bus.full, 1'b1);
        chk("t3_count_4", bus.count, 3'd4);
      end
      bus.wr_en   = 1'b1;
      bus.wr_oper = w3[i][7:4];
      bus.wr_dado = w3[i][3:0];
    end
    stop_wr();
    chk("t3_fifth_dropped", bus.count, 3'd4);
    fim_man    = 1'b0;
    latch_auto = 1'b1;
    wait_idle(100, "t3_idle");
    chk("t3_sent", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk("t3_order", got_q[i], w3[i]);

    // Stale fim keeps the emitter idle.
    latch_auto = 1'b0;
    fim_man    = 1'b1;
    push_word(4'hA, 4'h1);
    stop_wr();
    tick(3);
    chk("t4_hab_low", bus.hab, 1'b0);
    chk("t4_idle", bus.busy, 1'b0);
    chk("t4_count", bus.count, 3'd1);
    fim_man = 1'b0;
    @(negedge clk);
    chk("t4_drive_next", bus.hab, 1'b1);
    latch_auto = 1'b1;
    wait_idle(50, "t4_done");

    // Latch never answers.
    latch_auto = 1'b0;
    fim_man    = 1'b0;
    got_q.delete();
    push_word(4'hB, 4'hC);
    stop_wr();
`ifdef EMISSOR_TIMEOUT_EN
    wait_hab(1'b1, 5, "t5_hab_rise");
    hab_len(len);
    chk("t5_drive_cycles", len, TIMEOUT);
    chk("t5_erro_set", bus.erro, 1'b1);
    chk("t5_no_enviado", got_q.size(), 0);
    latch_auto = 1'b1;
    wait_idle(20, "t5_after_timeout");
    push_word(4'hD, 4'hE);
    stop_wr();
    wait_idle(50, "t5_next_sent");
    chk("t5_next_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t5_next_word", got_q[0], 8'hDE);
    chk("t5_erro_sticky", bus.erro, 1'b1);
    @(negedge clk);
    bus.clr_erro = 1'b1;
    @(negedge clk);
    bus.clr_erro = 1'b0;
    chk("t5_erro_clr", bus.erro, 1'b0);
`else
    tick(20);
    chk("t5_still_driving", bus.hab, 1'b1);
    chk("t5_word_held", bus.out_word, 8'hBC);
    bus.clr_erro = 1'b1;
    @(negedge clk);
    bus.clr_erro = 1'b0;
    chk("t5_erro_zero", bus.erro, 1'b0);
    latch_auto = 1'b1;
    wait_idle(50, "t5_done");
    chk("t5_sent", got_q.size(), 1);
    if (got_q.size() == 1) chk("t5_word", got_q[0], 8'hBC);
`endif

    // Simultaneous push and pop, then three full wraps.
    latch_auto = 1'b0;
    fim_man    = 1'b1;
    got_q.delete();
    push_word(4'h1, 4'h1);
    push_word(4'h2, 4'h2);
    @(negedge clk);
    chk("t6_count_2", bus.count, 3'd2);
    fim_man     = 1'b0;
    bus.wr_oper = 4'h3;
    bus.wr_dado = 4'h3;
    stop_wr();
    chk("t6_push_pop", bus.count, 3'd2);
    chk("t6_popped", bus.out_word, 8'h11);
    latch_auto = 1'b1;
    wait_idle(100, "t6_drain");
    for (int r = 0; r < 3; r++) begin
      latch_auto = 1'b0;
      fim_man    = 1'b1;
      for (int i = 0; i < 5; i++) push_word(4'(r + 4), 4'(i));
      stop_wr();
      chk("t6_wrap_full", bus.count, 3'd4);
      fim_man    = 1'b0;
      latch_auto = 1'b1;
      wait_idle(100, "t6_wrap_drain");
    end
    chk("t6_total_sent", got_q.size(), 15);
    if (got_q.size() == 15) begin
      chk("t6_last_word", got_q[14], 8'h63);
      chk("t6_third_word", got_q[2], 8'h33);
    end

    // Reset in the middle of a hab window.
    latch_auto = 1'b0;
    fim_man    = 1'b0;
    push_word(4'h7, 4'h7);
    push_word(4'h8, 4'h8);
    stop_wr();
    wait_hab(1'b1, 5, "t1_in_drive");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t1_hab", bus.hab, 1'b0);
    chk("t1_word", bus.out_word, 8'h00);
    chk("t1_count", bus.count, 3'd0);
    chk("t1_busy", bus.busy, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("t1_lost_words", bus.count, 3'd0);
    chk("t1_stay_idle", bus.hab, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
